// File: rtl/stream_demux_n.sv
// stream_demux_n: 1-to-NCH valid/ready demux with a one-entry register per output channel.
// The select is held for the whole packet. Define STREAM_DEMUX_CNT_EN to add per-channel beat counters.
//
// state  | meaning
// IDLE   | between packets; the next accepted beat routes by s_sel
// LOCKED | inside a multi-beat packet; beats route by lock_sel until s_last
module stream_demux_n #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  localparam int SW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  input  logic [SW-1:0]     s_sel,
  input  logic              s_last,
  output logic [NCH-1:0]    m_valid,
  input  logic [NCH-1:0]    m_ready,
  output logic [NCH*DW-1:0] m_data,
  output logic [NCH-1:0]    m_last,
`ifdef STREAM_DEMUX_CNT_EN
  output logic [NCH*16-1:0] beat_cnt,
`endif
  output logic              err_sel
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  logic [SW-1:0]   lock_sel;
  logic [SW-1:0]   esel;
  logic            in_range;
  logic            accept;
  logic [NCH-1:0]  hit;
  logic [NCH-1:0]  load;
  logic [NCH-1:0]  drain;

  assign esel = (state == LOCKED) ? lock_sel : s_sel;

  // With a power-of-two channel count every select value names a real channel.
  generate
    if ((1 << SW) == NCH) begin : g_pow2
      assign in_range = 1'b1;
    end else begin : g_npow2
      assign in_range = ({1'b0, esel} < (SW+1)'(NCH));
    end
  endgenerate

  always_comb begin
    hit = '0;
    for (int k = 0; k < NCH; k++) begin
      hit[k] = in_range & (esel == SW'(k));
    end
  end

  // Out-of-range beats are always taken so they can be dropped without stalling.
  assign s_ready = rst_n & (~in_range | (|(hit & (~m_valid | m_ready))));
  assign accept  = s_valid & s_ready;
  assign load    = hit & {NCH{accept}};
  assign drain   = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_sel <= '0;
      m_valid  <= '0;
      m_data   <= '0;
      m_last   <= '0;
      err_sel  <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          m_valid[k]          <= 1'b1;
          m_data[k*DW +: DW]  <= s_data;
          m_last[k]           <= s_last;
        end else if (drain[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
      if (accept && !in_range) begin
        err_sel <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (accept && !s_last) begin
            state    <= LOCKED;
            lock_sel <= s_sel;
          end
        end
        LOCKED: begin
          if (accept && s_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [NCH*16-1:0] cnt;

  // Dropped beats never reach m_valid, so counting handshakes excludes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (drain[k]) begin
          cnt[k*16 +: 16] <= cnt[k*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign beat_cnt = cnt;
`endif

endmodule
